// File: rtl/bullet_pkg.sv
// Shared constants and types for the bullet pool: default coordinate width,
// default sprite colour and the per-slot state record.
package bullet_pkg;

  localparam int          COORD_W_DFLT    = 10;
  localparam logic [11:0] BULLET_RGB_DFLT = 12'hFF0;

  // One bullet slot at the default coordinate width.
  typedef struct packed {
    logic                    active;
    logic [COORD_W_DFLT-1:0] x;
    logic [COORD_W_DFLT-1:0] y;
  } slot_t;

endpackage

// File: rtl/bullet_pool_if.sv
// Bundle of game-side signals for the bullet pool. The game logic / VGA
// mixer side drives through master; the pool itself sits on slave.
interface bullet_pool_if import bullet_pkg::*; #(
  parameter int NUM_BULLETS = 4,
  parameter int COORD_W     = COORD_W_DFLT
);

  logic                           move_tick;
  logic                           fire;
  logic [COORD_W-1:0]             start_x;
  logic [COORD_W-1:0]             start_y;
  logic [NUM_BULLETS-1:0]         hit;
  logic [COORD_W-1:0]             x;
  logic [COORD_W-1:0]             y;
  logic [NUM_BULLETS-1:0]         active;
  logic [NUM_BULLETS*COORD_W-1:0] b_x;
  logic [NUM_BULLETS*COORD_W-1:0] b_y;
  logic                           fire_ack;
  logic                           fire_drop;
  logic [11:0]                    mybullet_rgb;
  logic                           mybullet_en;

  modport master (
    output move_tick, fire, start_x, start_y, hit, x, y,
    input  active, b_x, b_y, fire_ack, fire_drop, mybullet_rgb, mybullet_en
  );

  modport slave (
    input  move_tick, fire, start_x, start_y, hit, x, y,
    output active, b_x, b_y, fire_ack, fire_drop, mybullet_rgb, mybullet_en
  );

endinterface

// File: rtl/bullet_slot.sv
// One bullet slot: live flag plus x/y position, with hit > move > load
// update priority and a combinational pixel-cover test against the scan.
module bullet_slot import bullet_pkg::*; #(
  parameter int COORD_W  = COORD_W_DFLT,
  parameter int SPEED    = 4,
  parameter int BULLET_W = 4,
  parameter int BULLET_H = 8,
  parameter int Y_MIN    = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hit_i,
  input  logic               move_i,
  input  logic               load_i,
  input  logic [COORD_W-1:0] start_x_i,
  input  logic [COORD_W-1:0] start_y_i,
  input  logic [COORD_W-1:0] pix_x_i,
  input  logic [COORD_W-1:0] pix_y_i,
  output logic               active_o,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               cover_o
);

  // Compares against the extents run one bit wider so sprites touching the
  // right/bottom edge never wrap back to low coordinates.
  localparam logic [COORD_W:0]   RETIRE_Y = (COORD_W+1)'(Y_MIN + SPEED);
  localparam logic [COORD_W:0]   SPAN_X   = (COORD_W+1)'(BULLET_W);
  localparam logic [COORD_W:0]   SPAN_Y   = (COORD_W+1)'(BULLET_H);
  localparam logic [COORD_W-1:0] STEP_Y   = COORD_W'(SPEED);

  logic               active_q, active_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;

  logic [COORD_W:0] x_wide, y_wide, px_wide, py_wide;

  // Next-state: kill on hit, else step up (or retire at the top), else load.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    active_d = active_q;
    x_d      = x_q;
    y_d      = y_q;
    if (hit_i && active_q) begin
      active_d = 1'b0;
    end else if (move_i && active_q) begin
      if ({1'b0, y_q} < RETIRE_Y) active_d = 1'b0;
      else                        y_d      = y_q - STEP_Y;
    end else if (load_i) begin
      active_d = 1'b1;
      x_d      = start_x_i;
      y_d      = start_y_i;
    end
  end

  // Slot state register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (rst) begin
      active_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      active_q <= active_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

  // Pixel-cover test on the current (pre-update) slot state.
  always_comb begin
    x_wide  = {1'b0, x_q};
    y_wide  = {1'b0, y_q};
    px_wide = {1'b0, pix_x_i};
    py_wide = {1'b0, pix_y_i};
    cover_o = active_q
           && (px_wide >= x_wide) && (px_wide < x_wide + SPAN_X)
           && (py_wide >= y_wide) && (py_wide < y_wide + SPAN_Y);
  end

  assign active_o = active_q;
  assign x_o      = x_q;
  assign y_o      = y_q;

endmodule

// File: rtl/bullet_pool.sv
// Multi-bullet manager: allocates the lowest free slot on fire (subject to a
// move_tick-based cooldown), advances and retires bullets, and renders a
// registered per-pixel colour/enable for the VGA mixer.
module bullet_pool import bullet_pkg::*; #(
  parameter int          NUM_BULLETS = 4,
  parameter int          COORD_W     = COORD_W_DFLT,
  parameter int          SPEED       = 4,
  parameter int          BULLET_W    = 4,
  parameter int          BULLET_H    = 8,
  parameter int          Y_MIN       = 0,
  parameter int          COOLDOWN    = 8,
  parameter logic [11:0] BULLET_RGB  = BULLET_RGB_DFLT
) (
  input logic         clk,
  input logic         rst,
  bullet_pool_if.slave bus
);

  localparam int CD_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

  logic [NUM_BULLETS-1:0] active_w;
  logic [NUM_BULLETS-1:0] cover_w;
  logic [NUM_BULLETS-1:0] load_w;
  logic [COORD_W-1:0]     x_w [NUM_BULLETS];
  logic [COORD_W-1:0]     y_w [NUM_BULLETS];

  logic            found;
  logic            accept, drop;
  logic [CD_W-1:0] cd_q, cd_d;
  logic            ack_q, drop_q;
  logic            en_q;
  logic [11:0]     rgb_q;

  // Lowest-index free slot; a slot hit this cycle is still live, so not free.
  always_comb begin
    load_w = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!active_w[i] && !found) begin
        load_w[i] = 1'b1;
        found     = 1'b1;
      end
    end
    accept = bus.fire && (cd_q == '0) && found;
    drop   = bus.fire && (cd_q == '0) && !found;
    if (!accept) load_w = '0;
  end

  // Cooldown: reload on accept (wins over a coincident tick), else count down.
  always_comb begin
    cd_d = cd_q;
    if (accept)                            cd_d = CD_W'(COOLDOWN);
    else if (bus.move_tick && cd_q != '0)  cd_d = cd_q - CD_W'(1);
  end

  // Cooldown, fire handshake pulses and registered render output.
  always_ff @(posedge clk) begin
    if (rst) begin
      cd_q   <= '0;
      ack_q  <= 1'b0;
      drop_q <= 1'b0;
      en_q   <= 1'b0;
      rgb_q  <= '0;
    end else begin
      cd_q   <= cd_d;
      ack_q  <= accept;
      drop_q <= drop;
      en_q   <= |cover_w;
      rgb_q  <= (|cover_w) ? BULLET_RGB : 12'h000;
    end
  end

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
    bullet_slot #(
      .COORD_W  (COORD_W),
      .SPEED    (SPEED),
      .BULLET_W (BULLET_W),
      .BULLET_H (BULLET_H),
      .Y_MIN    (Y_MIN)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .hit_i     (bus.hit[g]),
      .move_i    (bus.move_tick),
      .load_i    (load_w[g]),
      .start_x_i (bus.start_x),
      .start_y_i (bus.start_y),
      .pix_x_i   (bus.x),
      .pix_y_i   (bus.y),
      .active_o  (active_w[g]),
      .x_o       (x_w[g]),
      .y_o       (y_w[g]),
      .cover_o   (cover_w[g])
    );

    assign bus.b_x[g*COORD_W +: COORD_W] = x_w[g];
    assign bus.b_y[g*COORD_W +: COORD_W] = y_w[g];
  end

  assign bus.active       = active_w;
  assign bus.fire_ack     = ack_q;
  assign bus.fire_drop    = drop_q;
  assign bus.mybullet_en  = en_q;
  assign bus.mybullet_rgb = rgb_q;

endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench for bullet_pool at default parameters. Inputs change #1
// after a rising edge; outputs are sampled at that same point.
module tb_bullet_pool;

  localparam int N  = 4;
  localparam int CW = 10;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  bullet_pool_if #(.NUM_BULLETS(N), .COORD_W(CW)) bus ();

  bullet_pool #(.NUM_BULLETS(N), .COORD_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bx(input int i);
    return 32'(bus.b_x[i*CW +: CW]);
  endfunction

  function automatic logic [31:0] by(input int i);
    return 32'(bus.b_y[i*CW +: CW]);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic mtick(input int n);
    for (int k = 0; k < n; k++) begin
      bus.move_tick = 1'b1;
      cyc();
      bus.move_tick = 1'b0;
    end
  endtask

  task automatic do_fire(input int fx, input int fy);
    bus.fire    = 1'b1;
    bus.start_x = CW'(fx);
    bus.start_y = CW'(fy);
    cyc();
    bus.fire    = 1'b0;
  endtask

  task automatic scan(input int sx, input int sy);
    bus.x = CW'(sx);
    bus.y = CW'(sy);
    cyc();
  endtask

  initial begin
    bus.move_tick = 1'b0;
    bus.fire      = 1'b0;
    bus.start_x   = '0;
    bus.start_y   = '0;
    bus.hit       = '0;
    bus.x         = '0;
    bus.y         = '0;
    rst           = 1'b1;

    // Reset state
    do_reset();
    check("rst_active", 32'(bus.active), 0);
    check("rst_ack", 32'(bus.fire_ack), 0);
    check("rst_drop", 32'(bus.fire_drop), 0);
    check("rst_en", 32'(bus.mybullet_en), 0);
    check("rst_rgb", 32'(bus.mybullet_rgb), 0);
    check("rst_bx0", bx(0), 0);

    // First fire into slot 0
    do_fire(270, 430);
    check("f1_active", 32'(bus.active), 4'b0001);
    check("f1_bx0", bx(0), 270);
    check("f1_by0", by(0), 430);
    check("f1_ack", 32'(bus.fire_ack), 1);
    check("f1_drop", 32'(bus.fire_drop), 0);

    // Render at spawn position, registered one cycle
    scan(270, 430);
    check("r_en_hit", 32'(bus.mybullet_en), 1);
    check("r_rgb_hit", 32'(bus.mybullet_rgb), 12'hFF0);
    check("r_ack_gone", 32'(bus.fire_ack), 0);
    scan(274, 430);
    check("r_en_xout", 32'(bus.mybullet_en), 0);
    check("r_rgb_xout", 32'(bus.mybullet_rgb), 0);
    scan(273, 437);
    check("r_en_corner", 32'(bus.mybullet_en), 1);
    scan(273, 438);
    check("r_en_yout", 32'(bus.mybullet_en), 0);
    scan(269, 430);
    check("r_en_xleft", 32'(bus.mybullet_en), 0);

    // Three frame steps: 430 - 12
    mtick(3);
    check("mv_by0", by(0), 418);
    check("mv_bx0", bx(0), 270);

    // Fill the pool, 8 ticks apart (cooldown now 5)
    mtick(5);
    do_fire(100, 200);
    check("f2_ack", 32'(bus.fire_ack), 1);
    check("f2_active", 32'(bus.active), 4'b0011);
    mtick(8);
    do_fire(300, 300);
    check("f3_active", 32'(bus.active), 4'b0111);
    mtick(8);
    do_fire(400, 400);
    check("f4_active", 32'(bus.active), 4'b1111);
    check("f4_bx3", bx(3), 400);
    mtick(8);
    do_fire(500, 500);
    check("f5_drop", 32'(bus.fire_drop), 1);
    check("f5_ack", 32'(bus.fire_ack), 0);
    check("f5_active", 32'(bus.active), 4'b1111);
    check("f0_by_late", by(0), 302);

    // Kill slot 2, coordinates held, then reload it
    bus.hit = 4'b0100;
    cyc();
    bus.hit = '0;
    check("hit2_active", 32'(bus.active), 4'b1011);
    check("hit2_by2", by(2), 236);
    check("hit2_drop_gone", 32'(bus.fire_drop), 0);
    do_fire(50, 60);
    check("rl_ack", 32'(bus.fire_ack), 1);
    check("rl_active", 32'(bus.active), 4'b1111);
    check("rl_bx2", bx(2), 50);
    check("rl_by2", by(2), 60);

    // Reset mid-flight, then cooldown blocks a second fire
    do_reset();
    check("rst2_active", 32'(bus.active), 0);
    do_fire(10, 500);
    check("cd_f1_ack", 32'(bus.fire_ack), 1);
    mtick(2);
    do_fire(15, 505);
    check("cd_ign_ack", 32'(bus.fire_ack), 0);
    check("cd_ign_drop", 32'(bus.fire_drop), 0);
    check("cd_ign_active", 32'(bus.active), 4'b0001);
    mtick(5);
    do_fire(16, 506);
    check("cd_still_ack", 32'(bus.fire_ack), 0);
    mtick(1);
    do_fire(20, 600);
    check("cd_ok_ack", 32'(bus.fire_ack), 1);
    check("cd_ok_active", 32'(bus.active), 4'b0011);
    check("cd_ok_bx1", bx(1), 20);

    // Retire at the top without underflow
    do_reset();
    do_fire(100, 5);
    mtick(1);
    check("top_by0", by(0), 1);
    check("top_live", 32'(bus.active), 4'b0001);
    mtick(1);
    check("top_retired", 32'(bus.active), 0);
    check("top_by0_hold", by(0), 1);

    // Right-edge sprite does not wrap
    do_reset();
    do_fire(1020, 430);
    scan(1023, 430);
    check("edge_en_1023", 32'(bus.mybullet_en), 1);
    scan(3, 430);
    check("edge_en_3", 32'(bus.mybullet_en), 0);
    scan(1019, 430);
    check("edge_en_1019", 32'(bus.mybullet_en), 0);

    // Hit and move_tick together: hit wins, y holds
    do_reset();
    do_fire(100, 200);
    bus.hit       = 4'b0001;
    bus.move_tick = 1'b1;
    cyc();
    bus.hit       = '0;
    bus.move_tick = 1'b0;
    check("hm_active", 32'(bus.active), 0);
    check("hm_by0", by(0), 200);

    // Fire + move_tick + hit[1] with slot 1 the only live slot
    do_reset();
    do_fire(111, 222);
    mtick(8);
    do_fire(300, 300);
    bus.hit = 4'b0001;
    cyc();
    bus.hit = '0;
    check("mix_pre_active", 32'(bus.active), 4'b0010);
    mtick(8);
    check("mix_pre_by1", by(1), 268);
    bus.fire      = 1'b1;
    bus.start_x   = CW'(77);
    bus.start_y   = CW'(88);
    bus.move_tick = 1'b1;
    bus.hit       = 4'b0010;
    cyc();
    bus.fire      = 1'b0;
    bus.move_tick = 1'b0;
    bus.hit       = '0;
    check("mix_active", 32'(bus.active), 4'b0001);
    check("mix_bx0", bx(0), 77);
    check("mix_by0", by(0), 88);
    check("mix_ack", 32'(bus.fire_ack), 1);
    check("mix_by1_hold", by(1), 268);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
